// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt controller with latched/level capture, mask, timer and entry handshake
module irq_ctrl #(
    parameter int          NUM_IRQ     = 32,
    parameter logic [31:0] MASKED_IRQ  = 32'h0000_0000,
    parameter logic [31:0] LATCHED_IRQ = 32'hffff_ffff,
    parameter bit          TIMER_EN    = 1'b1,
    parameter int          TIMER_WIDTH = 32,
    parameter bit          PRIO_MODE   = 1'b0,
    parameter logic [31:0] VEC_BASE    = 32'h0000_0010,
    parameter int          VEC_STRIDE  = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_IRQ-1:0]     irq,
    input  logic                   boundary,
    output logic                   irq_req,
    input  logic                   irq_ack,
    output logic [31:0]            irq_vector,
    output logic                   save_pc_we,
    output logic                   save_pend_we,
    output logic [NUM_IRQ-1:0]     save_pend_data,
    input  logic                   retirq,
    input  logic                   maskirq_we,
    input  logic [NUM_IRQ-1:0]     maskirq_wdata,
    output logic [NUM_IRQ-1:0]     mask_rdata,
    input  logic                   timer_we,
    input  logic [TIMER_WIDTH-1:0] timer_wdata,
    output logic [TIMER_WIDTH-1:0] timer_rdata,
    output logic [NUM_IRQ-1:0]     eoi,
    output logic                   irq_active
);

    localparam logic [NUM_IRQ-1:0] LATCH_M   = LATCHED_IRQ[NUM_IRQ-1:0];
    localparam logic [NUM_IRQ-1:0] FORCE_OFF = MASKED_IRQ[NUM_IRQ-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SAVE_PC,
        S_SAVE_PEND,
        S_ACTIVE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [NUM_IRQ-1:0]     pending;
    logic [NUM_IRQ-1:0]     mask;
    logic [NUM_IRQ-1:0]     sel_cap;
    logic [NUM_IRQ-1:0]     eoi_q;
    logic [NUM_IRQ-1:0]     enabled;
    logic [NUM_IRQ-1:0]     sel;
    logic [NUM_IRQ-1:0]     clr;
    logic [NUM_IRQ-1:0]     pend_next;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   timer_fire;
    logic                   delay;
    logic [4:0]             sel_idx;

    always_comb begin
        enabled = pending & ~mask;
        sel_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (enabled[i]) sel_idx = 5'(i);
        end
        // Two's-complement trick isolates the lowest enabled channel.
        sel = PRIO_MODE ? (enabled & (~enabled + NUM_IRQ'(1))) : enabled;
    end

    always_comb begin
        timer_fire = (TIMER_EN != 1'b0) && !timer_we && (timer == TIMER_WIDTH'(1));
        clr        = (state == S_SAVE_PEND) ? sel_cap : '0;
        // A new edge arriving in the dispatch cycle survives the clear.
        pend_next    = (LATCH_M & ((pending & ~clr) | irq)) | (~LATCH_M & irq);
        pend_next[0] = pend_next[0] | timer_fire;
        pend_next    = pend_next & ~FORCE_OFF;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (boundary && (|enabled) && !delay) state_next = S_REQ;
            S_REQ: begin
                if (!(|enabled))  state_next = S_IDLE;
                else if (irq_ack) state_next = S_SAVE_PC;
            end
            S_SAVE_PC:   state_next = S_SAVE_PEND;
            S_SAVE_PEND: state_next = S_ACTIVE;
            S_ACTIVE:    if (retirq) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= S_IDLE;
            pending <= '0;
            mask    <= '1;
            timer   <= '0;
            sel_cap <= '0;
            eoi_q   <= '0;
            delay   <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pend_next;
            delay   <= (state == S_ACTIVE) && retirq;
            if (maskirq_we) mask <= maskirq_wdata;
            if (TIMER_EN) begin
                if (timer_we)            timer <= timer_wdata;
                else if (timer != '0)    timer <= timer - TIMER_WIDTH'(1);
            end
            if (state == S_SAVE_PC) sel_cap <= sel;
            if (state == S_SAVE_PEND)                eoi_q <= sel_cap;
            else if ((state == S_ACTIVE) && retirq)  eoi_q <= '0;
        end
    end

    assign irq_req        = (state == S_REQ);
    assign irq_vector     = (state != S_REQ) ? 32'h0 :
                            PRIO_MODE ? (VEC_BASE + 32'(sel_idx) * 32'(VEC_STRIDE)) : VEC_BASE;
    assign save_pc_we     = (state == S_SAVE_PC);
    assign save_pend_we   = (state == S_SAVE_PEND);
    assign save_pend_data = (state == S_SAVE_PEND) ? sel_cap : '0;
    assign irq_active     = (state == S_ACTIVE);
    assign mask_rdata     = mask;
    assign timer_rdata    = timer;
    assign eoi            = eoi_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - bench for irq_ctrl: bitmap and priority instances against a reference model
module tb_irq_ctrl;

    localparam logic [31:0] MASKED_P  = 32'h8000_0000;
    localparam logic [31:0] LATCHED_P = 32'hffff_fffb;

    logic        clk;
    logic        resetn;
    logic [31:0] irq;
    logic        boundary;
    logic        irq_ack;
    logic        retirq;
    logic        maskirq_we;
    logic [31:0] maskirq_wdata;
    logic        timer_we;
    logic [31:0] timer_wdata;

    logic        req [2];
    logic [31:0] vec [2];
    logic        pcwe [2];
    logic        pendwe [2];
    logic [31:0] pdata [2];
    logic [31:0] mrd [2];
    logic [31:0] trd [2];
    logic [31:0] eoi_o [2];
    logic        act [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, index 0 = bitmap instance, 1 = priority instance
    int          m_ph [2];
    logic [31:0] m_pend [2];
    logic [31:0] m_mask [2];
    logic [31:0] m_timer [2];
    logic [31:0] m_eoi [2];
    logic [31:0] m_cap [2];
    logic        m_cool [2];

    irq_ctrl #(.NUM_IRQ(32), .MASKED_IRQ(MASKED_P), .LATCHED_IRQ(LATCHED_P), .TIMER_EN(1'b1),
               .TIMER_WIDTH(32), .PRIO_MODE(1'b0), .VEC_BASE(32'h10), .VEC_STRIDE(16)) dut_b (
        .clk(clk), .resetn(resetn), .irq(irq), .boundary(boundary), .irq_req(req[0]),
        .irq_ack(irq_ack), .irq_vector(vec[0]), .save_pc_we(pcwe[0]), .save_pend_we(pendwe[0]),
        .save_pend_data(pdata[0]), .retirq(retirq), .maskirq_we(maskirq_we),
        .maskirq_wdata(maskirq_wdata), .mask_rdata(mrd[0]), .timer_we(timer_we),
        .timer_wdata(timer_wdata), .timer_rdata(trd[0]), .eoi(eoi_o[0]), .irq_active(act[0]));

    irq_ctrl #(.NUM_IRQ(32), .MASKED_IRQ(MASKED_P), .LATCHED_IRQ(LATCHED_P), .TIMER_EN(1'b1),
               .TIMER_WIDTH(32), .PRIO_MODE(1'b1), .VEC_BASE(32'h10), .VEC_STRIDE(16)) dut_p (
        .clk(clk), .resetn(resetn), .irq(irq), .boundary(boundary), .irq_req(req[1]),
        .irq_ack(irq_ack), .irq_vector(vec[1]), .save_pc_we(pcwe[1]), .save_pend_we(pendwe[1]),
        .save_pend_data(pdata[1]), .retirq(retirq), .maskirq_we(maskirq_we),
        .maskirq_wdata(maskirq_wdata), .mask_rdata(mrd[1]), .timer_we(timer_we),
        .timer_wdata(timer_wdata), .timer_rdata(trd[1]), .eoi(eoi_o[1]), .irq_active(act[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] irq;
        logic [6:0]  f;     // {boundary, ack, retirq, req, pc_we, pend_we, active}
        logic [31:0] pd;
        logic [31:0] eo;
        logic [31:0] vb;
        logic [31:0] vp;
    } row_t;

    row_t tbl [9];

    function automatic row_t mk(input logic [31:0] ir, input logic [6:0] f, input logic [31:0] pd,
                                input logic [31:0] eo, input logic [31:0] vb, input logic [31:0] vp);
        row_t r;
        r.irq = ir; r.f = f; r.pd = pd; r.eo = eo; r.vb = vb; r.vp = vp;
        return r;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, k, $time, got, exp);
        end
    endtask

    function automatic int low_idx(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] lowest_bit(input logic [31:0] v);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic compare_model();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] en;
            logic [31:0] ev;
            en = m_pend[k] & ~m_mask[k];
            ev = (m_ph[k] != 1) ? 32'h0 : (k == 1) ? 32'h10 + 32'(16 * low_idx(en)) : 32'h10;
            chk("m_req",    k, 32'(req[k]),    32'(m_ph[k] == 1));
            chk("m_vector", k, vec[k],         ev);
            chk("m_pc_we",  k, 32'(pcwe[k]),   32'(m_ph[k] == 2));
            chk("m_pend_we",k, 32'(pendwe[k]), 32'(m_ph[k] == 3));
            chk("m_pdata",  k, pdata[k],       (m_ph[k] == 3) ? m_cap[k] : 32'h0);
            chk("m_active", k, 32'(act[k]),    32'(m_ph[k] == 4));
            chk("m_eoi",    k, eoi_o[k],       m_eoi[k]);
            chk("m_mask",   k, mrd[k],         m_mask[k]);
            chk("m_timer",  k, trd[k],         m_timer[k]);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] en, sel, np, clr;
            logic        fire;
            int          nph;
            if (!resetn) begin
                m_ph[k] = 0; m_pend[k] = 0; m_mask[k] = 32'hffff_ffff; m_timer[k] = 0;
                m_eoi[k] = 0; m_cap[k] = 0; m_cool[k] = 1'b0;
            end else begin
                en   = m_pend[k] & ~m_mask[k];
                sel  = (k == 1) ? lowest_bit(en) : en;
                fire = (m_timer[k] == 1) && !timer_we;
                clr  = (m_ph[k] == 3) ? m_cap[k] : 32'h0;
                for (int i = 0; i < 32; i++) begin
                    if (MASKED_P[i])       np[i] = 1'b0;
                    else if (LATCHED_P[i]) np[i] = (m_pend[k][i] && !clr[i]) || irq[i];
                    else                   np[i] = irq[i];
                end
                if (fire && !MASKED_P[0]) np[0] = 1'b1;
                nph = m_ph[k];
                case (m_ph[k])
                    0: if (boundary && en != 0 && !m_cool[k]) nph = 1;
                    1: if (en == 0) nph = 0; else if (irq_ack) nph = 2;
                    2: begin m_cap[k] = sel; nph = 3; end
                    3: begin m_eoi[k] = m_cap[k]; nph = 4; end
                    default: if (retirq) begin m_eoi[k] = 0; nph = 0; end
                endcase
                m_cool[k] = (m_ph[k] == 4) && retirq;
                m_ph[k]   = nph;
                m_pend[k] = np;
                if (maskirq_we) m_mask[k] = maskirq_wdata;
                if (timer_we) m_timer[k] = timer_wdata;
                else if (m_timer[k] != 0) m_timer[k] = m_timer[k] - 1;
            end
        end
    endtask

    task automatic tick();
        compare_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_req(input int k, input int budget, input string nm);
        int n;
        n = 0;
        while (!req[k] && n < budget) begin
            tick();
            n++;
        end
        chk(nm, k, 32'(req[k]), 32'h1);
    endtask

    task automatic check_reset_outputs(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk({nm, "_req"},   k, 32'(req[k]),    32'h0);
            chk({nm, "_pcwe"},  k, 32'(pcwe[k]),   32'h0);
            chk({nm, "_pendwe"},k, 32'(pendwe[k]), 32'h0);
            chk({nm, "_pdata"}, k, pdata[k],       32'h0);
            chk({nm, "_eoi"},   k, eoi_o[k],       32'h0);
            chk({nm, "_act"},   k, 32'(act[k]),    32'h0);
            chk({nm, "_mask"},  k, mrd[k],         32'hffff_ffff);
            chk({nm, "_timer"}, k, trd[k],         32'h0);
        end
    endtask

    task automatic write_mask(input logic [31:0] m);
        maskirq_we = 1'b1; maskirq_wdata = m;
        tick();
        maskirq_we = 1'b0;
    endtask

    initial begin
        logic [31:0] disp [2][4];
        logic [31:0] dvec [2][4];
        logic [31:0] last_vec [2];
        int          nd [2];
        int          seen;

        resetn = 1'b0; irq = 0; boundary = 1'b0; irq_ack = 1'b0; retirq = 1'b0;
        maskirq_we = 1'b0; maskirq_wdata = 0; timer_we = 1'b0; timer_wdata = 0;
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 0; m_pend[k] = 0; m_mask[k] = 32'hffff_ffff; m_timer[k] = 0;
            m_eoi[k] = 0; m_cap[k] = 0; m_cool[k] = 1'b0;
        end
        @(negedge clk);
        tick(); tick();
        resetn = 1'b1;
        check_reset_outputs("rst");
        write_mask(32'h0);

        // Single pulse on irq[5], full entry and return
        tbl[0] = mk(32'h20, 7'b100_0000, 0, 0, 0, 0);
        tbl[1] = mk(32'h0,  7'b100_0000, 0, 0, 0, 0);
        tbl[2] = mk(32'h0,  7'b100_1000, 0, 0, 32'h10, 32'h60);
        tbl[3] = mk(32'h0,  7'b110_1000, 0, 0, 32'h10, 32'h60);
        tbl[4] = mk(32'h0,  7'b100_0100, 0, 0, 0, 0);
        tbl[5] = mk(32'h0,  7'b100_0010, 32'h20, 0, 0, 0);
        tbl[6] = mk(32'h0,  7'b100_0001, 0, 32'h20, 0, 0);
        tbl[7] = mk(32'h0,  7'b101_0001, 0, 32'h20, 0, 0);
        tbl[8] = mk(32'h0,  7'b100_0000, 0, 0, 0, 0);
        for (int r = 0; r < 9; r++) begin
            irq = tbl[r].irq; boundary = tbl[r].f[6]; irq_ack = tbl[r].f[5]; retirq = tbl[r].f[4];
            for (int k = 0; k < 2; k++) begin
                chk("t_req",    k, 32'(req[k]),    32'(tbl[r].f[3]));
                chk("t_pcwe",   k, 32'(pcwe[k]),   32'(tbl[r].f[2]));
                chk("t_pendwe", k, 32'(pendwe[k]), 32'(tbl[r].f[1]));
                chk("t_active", k, 32'(act[k]),    32'(tbl[r].f[0]));
                chk("t_pdata",  k, pdata[k],       tbl[r].pd);
                chk("t_eoi",    k, eoi_o[k],       tbl[r].eo);
                chk("t_vector", k, vec[k],         (k == 1) ? tbl[r].vp : tbl[r].vb);
            end
            tick();
        end
        irq_ack = 1'b0; retirq = 1'b0; boundary = 1'b0;
        tick(); tick();

        // irq[3] and irq[9] together: one bitmap dispatch vs two priority dispatches
        irq = 32'h208; boundary = 1'b1; irq_ack = 1'b1; retirq = 1'b1;
        tick();
        irq = 0;
        nd[0] = 0; nd[1] = 0; last_vec[0] = 0; last_vec[1] = 0;
        for (int c = 0; c < 20; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (req[k]) last_vec[k] = vec[k];
                if (pendwe[k] && nd[k] < 4) begin
                    disp[k][nd[k]] = pdata[k];
                    dvec[k][nd[k]] = last_vec[k];
                    nd[k]++;
                end
            end
            tick();
        end
        irq_ack = 1'b0; retirq = 1'b0; boundary = 1'b0;
        chk("two_b_count", 0, 32'(nd[0]), 32'd1);
        chk("two_p_count", 1, 32'(nd[1]), 32'd2);
        if (nd[0] >= 1) begin
            chk("two_b_data", 0, disp[0][0], 32'h208);
            chk("two_b_vec",  0, dvec[0][0], 32'h10);
        end
        if (nd[1] >= 2) begin
            chk("two_p_data0", 1, disp[1][0], 32'h8);
            chk("two_p_vec0",  1, dvec[1][0], 32'h40);
            chk("two_p_data1", 1, disp[1][1], 32'h200);
            chk("two_p_vec1",  1, dvec[1][1], 32'ha0);
        end
        tick(); tick();

        // Timer countdown raises channel 0
        timer_we = 1'b1; timer_wdata = 3;
        tick();
        timer_we = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("tmr_count", 0, trd[0], 32'(3 - j));
            tick();
        end
        boundary = 1'b1;
        tick();
        chk("tmr_req", 0, 32'(req[0]), 32'h1);
        chk("tmr_req", 1, 32'(req[1]), 32'h1);
        chk("tmr_vec", 1, vec[1], 32'h10);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        tick();
        chk("tmr_pdata", 0, pdata[0], 32'h1);
        chk("tmr_pdata", 1, pdata[1], 32'h1);
        tick();
        retirq = 1'b1; tick(); retirq = 1'b0;
        tick();

        // Reload in the expiry cycle suppresses the interrupt; load 0 stops the timer
        timer_we = 1'b1; timer_wdata = 2; tick(); timer_we = 1'b0;
        chk("tmr2_cnt2", 0, trd[0], 32'd2);
        tick();
        chk("tmr2_cnt1", 0, trd[0], 32'd1);
        timer_we = 1'b1; timer_wdata = 5; tick(); timer_we = 1'b0;
        chk("tmr2_reload", 0, trd[0], 32'd5);
        chk("tmr2_noreq", 0, 32'(req[0]), 32'h0);
        timer_we = 1'b1; timer_wdata = 0; tick(); timer_we = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("tmr2_stop",   1, trd[1], 32'd0);
            chk("tmr2_noreq2", 1, 32'(req[1]), 32'h0);
            tick();
        end

        // Level channel 2 drops while requesting: withdraw
        irq = 32'h4;
        wait_req(0, 6, "lvl_req");
        irq = 0;
        tick(); tick();
        chk("lvl_withdraw", 0, 32'(req[0]), 32'h0);
        chk("lvl_withdraw", 1, 32'(req[1]), 32'h0);
        seen = 0;
        for (int j = 0; j < 3; j++) begin
            if (pcwe[0] || pcwe[1] || pendwe[0] || pendwe[1]) seen++;
            tick();
        end
        chk("lvl_nostrobe", 0, 32'(seen), 32'd0);

        // Masking everything in REQ withdraws; unmasking finds the latched bit again
        irq = 32'h10; tick(); irq = 0;
        wait_req(0, 6, "msk_req");
        maskirq_we = 1'b1; maskirq_wdata = 32'hffff_ffff;
        chk("msk_old", 0, mrd[0], 32'h0);
        tick();
        maskirq_we = 1'b0;
        chk("msk_new", 0, mrd[0], 32'hffff_ffff);
        tick();
        chk("msk_withdraw", 0, 32'(req[0]), 32'h0);
        chk("msk_withdraw", 1, 32'(req[1]), 32'h0);
        write_mask(32'hffff_ffef);
        wait_req(1, 6, "msk_rereq");
        chk("msk_vec", 1, vec[1], 32'h50);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        tick();
        chk("msk_pdata", 0, pdata[0], 32'h10);
        chk("msk_pdata", 1, pdata[1], 32'h10);
        tick();
        retirq = 1'b1; tick(); retirq = 1'b0;
        write_mask(32'h0);

        // Reset during SAVE_PC cancels the remaining strobe
        irq = 32'h40; tick(); irq = 0;
        wait_req(0, 6, "rst_req");
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("rst_pcwe", 0, 32'(pcwe[0]), 32'h1);
        resetn = 1'b0; tick(); resetn = 1'b1;
        check_reset_outputs("mid_rst");
        seen = 0;
        for (int j = 0; j < 3; j++) begin
            if (pendwe[0] || pendwe[1]) seen++;
            tick();
        end
        chk("rst_nopend", 0, 32'(seen), 32'd0);

        // Permanently masked channel 31 never requests
        write_mask(32'h0);
        irq = 32'h8000_0000; tick(); irq = 0;
        seen = 0;
        for (int j = 0; j < 5; j++) begin
            if (req[0] || req[1]) seen++;
            tick();
        end
        chk("forced_off", 0, 32'(seen), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] ir;
            ir = 32'h0;
            if ($urandom_range(0, 2) == 0) ir[$urandom_range(0, 31)] = 1'b1;
            if ($urandom_range(0, 1) == 1) ir[2] = 1'b1;
            irq        = ir;
            resetn     = ($urandom_range(0, 299) != 0);
            boundary   = ($urandom_range(0, 3) != 0);
            irq_ack    = ($urandom_range(0, 1) == 1);
            retirq     = ($urandom_range(0, 4) == 0);
            maskirq_we = ($urandom_range(0, 19) == 0);
            maskirq_wdata = ($urandom_range(0, 1) == 1) ? 32'h0 : ($urandom & $urandom);
            timer_we   = ($urandom_range(0, 24) == 0);
            timer_wdata = $urandom_range(0, 6);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
